// File: rtl/systolic_feeder.sv
// systolic_feeder: loads a 2x2 weight matrix into a systolic array, pulses
// the switch, then streams activation vectors with a one-cycle row skew,
// flushes the last row-2 element and drains before signalling done.
// Every sys_* output is a register whose next value is decoded from the
// current state and inputs, so each output appears one cycle after the
// state that produced it.
module systolic_feeder #(
    parameter int DATA_W       = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_w11,
    input  logic [DATA_W-1:0] cfg_w12,
    input  logic [DATA_W-1:0] cfg_w21,
    input  logic [DATA_W-1:0] cfg_w22,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x1,
    input  logic [DATA_W-1:0] in_x2,
    input  logic              in_last,
    output logic              sys_start,
    output logic              sys_switch_in,
    output logic              sys_accept_w_in,
    output logic [DATA_W-1:0] sys_data_in_11,
    output logic [DATA_W-1:0] sys_data_in_12,
    output logic [DATA_W-1:0] sys_weight_in_11,
    output logic [DATA_W-1:0] sys_weight_in_12,
    output logic              busy,
    output logic              done
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, SWITCH, STREAM, FLUSH, DRAIN} state_t;

    state_t            state, state_n;
    logic [1:0]        k, k_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] skew, skew_n;
    logic [DATA_W-1:0] w11, w12, w21, w22;

    logic              start_n, switch_n, accept_n, done_n;
    logic [DATA_W-1:0] d11_n, d12_n, wi11_n, wi12_n;

    assign cfg_ready = (state == IDLE);
    assign in_ready  = (state == STREAM);
    assign busy      = (state != IDLE);

    // Next-state and next-output decode; all outputs default to zero.
    always_comb begin
        state_n  = state;
        k_n      = k;
        cnt_n    = cnt;
        skew_n   = '0;
        start_n  = 1'b0;
        switch_n = 1'b0;
        accept_n = 1'b0;
        done_n   = 1'b0;
        d11_n    = '0;
        d12_n    = '0;
        wi11_n   = '0;
        wi12_n   = '0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    state_n = LOAD_W;
                    k_n     = 2'd0;
                end
            end
            LOAD_W: begin
                // Column 2 trails column 1 by one cycle to track the
                // accept_w pipeline inside the array.
                case (k)
                    2'd0: begin
                        accept_n = 1'b1;
                        wi11_n   = w21;
                        k_n      = 2'd1;
                    end
                    2'd1: begin
                        accept_n = 1'b1;
                        wi11_n   = w11;
                        wi12_n   = w22;
                        k_n      = 2'd2;
                    end
                    default: begin
                        wi12_n  = w12;
                        k_n     = 2'd0;
                        state_n = SWITCH;
                    end
                endcase
            end
            SWITCH: begin
                switch_n = 1'b1;
                state_n  = STREAM;
            end
            STREAM: begin
                // Row 2 always shifts, so bubbles keep their alignment.
                d12_n = skew;
                if (in_valid) begin
                    start_n = 1'b1;
                    d11_n   = in_x1;
                    skew_n  = in_x2;
                    if (in_last) state_n = FLUSH;
                end
            end
            FLUSH: begin
                d12_n   = skew;
                cnt_n   = '0;
                state_n = DRAIN;
            end
            DRAIN: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Control state, counters, skew register and weight latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            cnt   <= '0;
            skew  <= '0;
            w11   <= '0;
            w12   <= '0;
            w21   <= '0;
            w22   <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            cnt   <= cnt_n;
            skew  <= skew_n;
            if (state == IDLE && cfg_valid) begin
                w11 <= cfg_w11;
                w12 <= cfg_w12;
                w21 <= cfg_w21;
                w22 <= cfg_w22;
            end
        end
    end

    // Registered array-facing outputs and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sys_start        <= 1'b0;
            sys_switch_in    <= 1'b0;
            sys_accept_w_in  <= 1'b0;
            sys_data_in_11   <= '0;
            sys_data_in_12   <= '0;
            sys_weight_in_11 <= '0;
            sys_weight_in_12 <= '0;
            done             <= 1'b0;
        end else begin
            sys_start        <= start_n;
            sys_switch_in    <= switch_n;
            sys_accept_w_in  <= accept_n;
            sys_data_in_11   <= d11_n;
            sys_data_in_12   <= d12_n;
            sys_weight_in_11 <= wi11_n;
            sys_weight_in_12 <= wi12_n;
            done             <= done_n;
        end
    end

endmodule
